// File: rtl/lstm_seq_ctrl.sv
`timescale 1ns/1ps
// lstm_seq_ctrl
// Multi-timestep sequencer wrapped around a single-step LSTM cell.
// Accepts one N_CH-lane input vector per timestep and pulses the cell.
// The cell's hidden output is fed back as the next step's cell_h.
// Hidden vectors are emitted on every step, or on the last step only.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   seq_start/seq_abort  sequence control pulses
//   cfg_seq_len          sequence length, sampled on an accepted seq_start
//   cfg_emit_all         sampled with seq_start
//   cfg_keep_h           sampled with seq_start
//   in_valid/in_ready    per-step input vector handshake, data on in_x
//   cell_*               cell interface: clear/start pulses, operands,
//                        finished pulse and new hidden vector
//   out_valid/out_ready  hidden vector output handshake (out_h, out_last)
//   step_idx             current timestep (0-based)
//   busy                 high whenever the sequencer is not idle
//   seq_done             one-cycle pulse when a sequence completes
//   err_timeout          sticky cell timeout flag
module lstm_seq_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int N_CH        = 4,
  parameter int SEQ_LEN_MAX = 16,
  parameter int TIMEOUT_CYC = 255,
  localparam int LEN_W      = $clog2(SEQ_LEN_MAX + 1),
  localparam int VEC_W      = N_CH * DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seq_start,
  input  logic             seq_abort,
  input  logic [LEN_W-1:0] cfg_seq_len,
  input  logic             cfg_emit_all,
  input  logic             cfg_keep_h,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] in_x,
  output logic             cell_clear,
  output logic             cell_start,
  output logic [VEC_W-1:0] cell_x,
  output logic [VEC_W-1:0] cell_h,
  input  logic             cell_finished,
  input  logic [VEC_W-1:0] cell_h_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VEC_W-1:0] out_h,
  output logic             out_last,
  output logic [LEN_W-1:0] step_idx,
  output logic             busy,
  output logic             seq_done,
  output logic             err_timeout
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_X,
    S_START,
    S_RUN,
    S_EMIT
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               emit_all_q, emit_all_d;
  logic [LEN_W-1:0]   step_q, step_d;
  logic [VEC_W-1:0]   h_q, h_d;
  logic [VEC_W-1:0]   x_q, x_d;
  logic               err_q, err_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               clear_q, clear_d;
  logic               done_q, done_d;

  logic [LEN_W-1:0]   len_clamped;
  logic               is_last;

  assign len_clamped = (cfg_seq_len > LEN_W'(SEQ_LEN_MAX)) ? LEN_W'(SEQ_LEN_MAX)
                                                           : cfg_seq_len;
  // len_q is never zero outside IDLE, so len_q - 1 cannot underflow where used.
  assign is_last     = (step_q == (len_q - LEN_W'(1)));

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    state_d    = state_q;
    len_d      = len_q;
    emit_all_d = emit_all_q;
    step_d     = step_q;
    h_d        = h_q;
    x_d        = x_q;
    err_d      = err_q;
    tmo_d      = tmo_q;
    clear_d    = 1'b0;
    done_d     = 1'b0;

    if (seq_abort) begin
      // Abort beats everything, including a start in IDLE; h_reg is kept.
      state_d = S_IDLE;
      tmo_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (seq_start) begin
            len_d      = len_clamped;
            emit_all_d = cfg_emit_all;
            step_d     = '0;
            err_d      = 1'b0;
            if (!cfg_keep_h) h_d = '0;
            if (len_clamped == '0) begin
              done_d = 1'b1;
            end else begin
              clear_d = 1'b1;
              state_d = S_WAIT_X;
            end
          end
        end

        S_WAIT_X: begin
          if (in_valid) begin
            x_d     = in_x;
            state_d = S_START;
          end
        end

        S_START: begin
          tmo_d   = '0;
          state_d = S_RUN;
        end

        S_RUN: begin
          // The timeout is checked first: a finish arriving in the very last
          // allowed cycle still loses to the timeout.
          if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
            err_d   = 1'b1;
            tmo_d   = '0;
            state_d = S_IDLE;
          end else if (cell_finished) begin
            h_d   = cell_h_out;
            tmo_d = '0;
            if (emit_all_q || is_last) begin
              state_d = S_EMIT;
            end else begin
              step_d  = step_q + LEN_W'(1);
              state_d = S_WAIT_X;
            end
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end

        S_EMIT: begin
          if (out_ready) begin
            if (is_last) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              step_d  = step_q + LEN_W'(1);
              state_d = S_WAIT_X;
            end
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      emit_all_q <= 1'b0;
      step_q     <= '0;
      h_q        <= '0;
      x_q        <= '0;
      err_q      <= 1'b0;
      tmo_q      <= '0;
      clear_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      emit_all_q <= emit_all_d;
      step_q     <= step_d;
      h_q        <= h_d;
      x_q        <= x_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
      clear_q    <= clear_d;
      done_q     <= done_d;
    end
  end

  assign in_ready    = (state_q == S_WAIT_X);
  assign cell_start  = (state_q == S_START);
  assign cell_clear  = clear_q;
  assign cell_x      = x_q;
  assign cell_h      = h_q;
  assign out_valid   = (state_q == S_EMIT);
  assign out_h       = h_q;
  assign out_last    = (state_q == S_EMIT) && is_last;
  assign step_idx    = step_q;
  assign busy        = (state_q != S_IDLE);
  assign seq_done    = done_q;
  assign err_timeout = err_q;

endmodule
